tx_chan_arbiter: RTL and testbench

- Shares the single transmit chain between NUM_CHAN channel FIFO readers.
- Forwards pkt_waiting and tx_strobe only to the granted reader.
- Muxes that reader's tx_i/tx_q/tx_empty onto the tx chain.
- Grants are round-robin per packet. A grant is held across a multi-packet burst (STARTOFBURST to ENDOFBURST), with a timeout guard so a stalled burst cannot lock the chain.

---
 rtl/tx_chan_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_tx_chan_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_chan_arbiter.sv
// Round-robin owner of the shared tx chain, with burst hold and hold timeout.
// Define TX_ARB_PRIORITY_EN to make channel 0 win every arbitration it enters.
module tx_chan_arbiter #(
  parameter int NUM_CHAN     = 4,
  parameter int HOLD_TIMEOUT = 4096
) (
  input  logic                  tx_clock,
  input  logic                  reset,
  input  logic [NUM_CHAN-1:0]   pkt_waiting_in,
  input  logic [32*NUM_CHAN-1:0] header_in,
  input  logic [NUM_CHAN-1:0]   skip_in,
  input  logic [16*NUM_CHAN-1:0] tx_i_in,
  input  logic [16*NUM_CHAN-1:0] tx_q_in,
  input  logic [NUM_CHAN-1:0]   tx_empty_in,
  input  logic                  tx_strobe,
  output logic [NUM_CHAN-1:0]   pkt_waiting_out,
  output logic [NUM_CHAN-1:0]   tx_strobe_out,
  output logic [15:0]           tx_i,
  output logic [15:0]           tx_q,
  output logic                  tx_empty,
  output logic [NUM_CHAN-1:0]   grant,
  output logic                  burst_lock,
  output logic                  timeout_err,
  output logic [15:0]           debug
);

  localparam int CW = $clog2(HOLD_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_TIMEOUT - 1);

  // Encoding is visible on debug[5:4].
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    HOLD   = 2'b10
  } state_t;

  state_t              state, state_n;
  logic [1:0]          last, last_n;
  logic [1:0]          gidx, win, rr_c;
  logic                found;
  logic [NUM_CHAN-1:0] grant_n, req, sob, eob;
  logic [CW-1:0]       cnt, cnt_n;
  logic                lock_n, terr_n;
  logic                skip_g, pw_g;
  logic [15:0]         ch_i [NUM_CHAN];
  logic [15:0]         ch_q [NUM_CHAN];
  logic [3:0]          grant4;

  for (genvar k = 0; k < NUM_CHAN; k++) begin : g_chan
    assign sob[k]  = header_in[32*k+28];
    assign eob[k]  = header_in[32*k+27];
    assign ch_i[k] = tx_i_in[16*k +: 16];
    assign ch_q[k] = tx_q_in[16*k +: 16];
  end

  function automatic logic lock_rule(
    input logic cur,
    input logic s,
    input logic e
  );
    if (e)
      return 1'b0;
    else if (s)
      return 1'b1;
    return cur;
  endfunction

  always_comb begin
    gidx = '0;
    for (int k = 0; k < NUM_CHAN; k++)
      if (grant[k])
        gidx = 2'(k);
  end

  assign skip_g = |(skip_in & grant);
  assign pw_g   = |(pkt_waiting_in & grant);

  // Search starts one past the last owner so every requester gets a turn.
  always_comb begin
    req = pkt_waiting_in;
`ifdef TX_ARB_PRIORITY_EN
    req[0] = 1'b0;
`endif
    win   = '0;
    found = 1'b0;
    rr_c  = '0;
    for (int k = 1; k <= NUM_CHAN; k++) begin
      rr_c = 2'((int'(last) + k) % NUM_CHAN);
      if (!found && req[rr_c]) begin
        win   = rr_c;
        found = 1'b1;
      end
    end
`ifdef TX_ARB_PRIORITY_EN
    if (pkt_waiting_in[0])
      win = 2'd0;
`endif
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    lock_n  = burst_lock;
    last_n  = last;
    cnt_n   = cnt;
    terr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|pkt_waiting_in) begin
          state_n = ACTIVE;
          grant_n = NUM_CHAN'(1) << win;
          lock_n  = lock_rule(burst_lock, sob[win], eob[win]);
        end
      end
      ACTIVE: begin
        if (skip_g) begin
          if (burst_lock) begin
            state_n = HOLD;
            cnt_n   = '0;
          end else begin
            state_n = IDLE;
            grant_n = '0;
            last_n  = gidx;
          end
        end
      end
      HOLD: begin
        if (pw_g) begin
          state_n = ACTIVE;
          lock_n  = lock_rule(burst_lock, sob[gidx], eob[gidx]);
        end else if (cnt == CNT_MAX) begin
          state_n = IDLE;
          grant_n = '0;
          lock_n  = 1'b0;
          last_n  = gidx;
          terr_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        lock_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge tx_clock) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      burst_lock  <= 1'b0;
      timeout_err <= 1'b0;
      last        <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      burst_lock  <= lock_n;
      timeout_err <= terr_n;
      last        <= last_n;
      cnt         <= cnt_n;
    end
  end

  always_ff @(posedge tx_clock) begin
    if (reset || grant == '0) begin
      tx_i     <= '0;
      tx_q     <= '0;
      tx_empty <= 1'b1;
    end else begin
      tx_i     <= ch_i[gidx];
      tx_q     <= ch_q[gidx];
      tx_empty <= tx_empty_in[gidx];
    end
  end

  assign pkt_waiting_out = (state == ACTIVE) ? (grant & pkt_waiting_in) : '0;
  assign tx_strobe_out   = (state != IDLE) ? (grant & {NUM_CHAN{tx_strobe}}) : '0;

  assign grant4 = 4'(grant);
  assign debug  = {8'd0, burst_lock, timeout_err, state, grant4};

endmodule

// File: tb/tb_tx_chan_arbiter.sv
// Randomized scoreboard bench for tx_chan_arbiter with a channel-level model.
// Short HOLD_TIMEOUT so hold expiry is exercised often.
module tb_tx_chan_arbiter;

  localparam int N  = 4;
  localparam int HT = 16;

  logic            tx_clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    pkt_waiting_in = '0;
  logic [32*N-1:0] header_in = '0;
  logic [N-1:0]    skip_in = '0;
  logic [16*N-1:0] tx_i_in = '0;
  logic [16*N-1:0] tx_q_in = '0;
  logic [N-1:0]    tx_empty_in = '0;
  logic            tx_strobe = 1'b0;
  logic [N-1:0]    pkt_waiting_out, tx_strobe_out, grant;
  logic [15:0]     tx_i, tx_q, debug;
  logic            tx_empty, burst_lock, timeout_err;

  tx_chan_arbiter #(.NUM_CHAN(N), .HOLD_TIMEOUT(HT)) dut (
    .tx_clock(tx_clock), .reset(reset),
    .pkt_waiting_in(pkt_waiting_in), .header_in(header_in),
    .skip_in(skip_in), .tx_i_in(tx_i_in), .tx_q_in(tx_q_in),
    .tx_empty_in(tx_empty_in), .tx_strobe(tx_strobe),
    .pkt_waiting_out(pkt_waiting_out), .tx_strobe_out(tx_strobe_out),
    .tx_i(tx_i), .tx_q(tx_q), .tx_empty(tx_empty), .grant(grant),
    .burst_lock(burst_lock), .timeout_err(timeout_err), .debug(debug)
  );

  always #5 tx_clock = ~tx_clock;

  typedef struct {
    logic [3:0]  grant;
    logic        lock;
    logic        terr;
    logic [15:0] ti;
    logic [15:0] tq;
    logic        te;
    logic [15:0] dbg;
  } exp_r_t;

  typedef struct {
    logic [3:0] pwo;
    logic [3:0] tso;
  } exp_c_t;

  exp_r_t qr[$];
  exp_c_t qc[$];
  int vectors = 0;
  int miscompares = 0;

  // Model: owner channel (-1 = nobody), whether it is parked waiting for
  // the next burst packet, and how long it has waited.
  int m_owner = -1;
  bit m_hold = 0;
  bit m_lock = 0;
  int m_wait = 0;
  int m_last = 0;
  bit m_valid = 0;

  bit         g_rst = 1;
  logic [3:0] g_pw = 0, g_sk = 0, g_sob = 0, g_eob = 0;
  logic       g_ts = 0;

  function automatic int pick();
`ifdef TX_ARB_PRIORITY_EN
    if (pkt_waiting_in[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (pkt_waiting_in[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit hdr_lock(int c);
    if (g_eob[c]) return 0;
    if (g_sob[c]) return 1;
    return m_lock;
  endfunction

  function automatic logic [3:0] own_mask();
    return (m_owner < 0) ? 4'd0 : 4'(1 << m_owner);
  endfunction

  task automatic model_step();
    exp_r_t e;
    int     w;
    bit     terr;
    terr = 0;
    if (reset) begin
      m_owner = -1; m_hold = 0; m_lock = 0; m_wait = 0; m_last = 0;
      m_valid = 1;
      e.ti = 0; e.tq = 0; e.te = 1;
    end else begin
      if (m_owner < 0) begin
        e.ti = 0; e.tq = 0; e.te = 1;
      end else begin
        e.ti = tx_i_in[16*m_owner +: 16];
        e.tq = tx_q_in[16*m_owner +: 16];
        e.te = tx_empty_in[m_owner];
      end
      if (m_owner < 0) begin
        w = pick();
        if (w >= 0) begin
          m_lock  = hdr_lock(w);
          m_owner = w;
          m_hold  = 0;
        end
      end else if (!m_hold) begin
        if (skip_in[m_owner]) begin
          if (m_lock) begin
            m_hold = 1; m_wait = 0;
          end else begin
            m_last = m_owner; m_owner = -1;
          end
        end
      end else if (pkt_waiting_in[m_owner]) begin
        m_hold = 0;
        m_lock = hdr_lock(m_owner);
      end else if (m_wait == HT - 1) begin
        m_last = m_owner; m_owner = -1; m_hold = 0; m_lock = 0;
        terr = 1;
      end else begin
        m_wait++;
      end
    end
    e.grant = own_mask();
    e.lock  = m_lock;
    e.terr  = terr;
    e.dbg   = {8'd0, m_lock, terr,
               (m_owner < 0) ? 2'd0 : (m_hold ? 2'd2 : 2'd1), e.grant};
    qr.push_back(e);
  endtask

  task automatic cycle();
    exp_c_t c;
    @(negedge tx_clock);
    reset          = g_rst;
    pkt_waiting_in = g_pw;
    skip_in        = g_sk;
    tx_strobe      = g_ts;
    tx_empty_in    = 4'($urandom);
    for (int k = 0; k < N; k++) begin
      header_in[32*k +: 32] = $urandom;
      header_in[32*k+28]    = g_sob[k];
      header_in[32*k+27]    = g_eob[k];
      tx_i_in[16*k +: 16]   = 16'($urandom);
      tx_q_in[16*k +: 16]   = 16'($urandom);
    end
    #1;
    if (m_valid) begin
      c.pwo = (m_owner >= 0 && !m_hold) ? (pkt_waiting_in & own_mask()) : 4'd0;
      c.tso = g_ts ? own_mask() : 4'd0;
      qc.push_back(c);
    end
    model_step();
    g_sk = 0;
  endtask

  always @(negedge tx_clock) begin
    exp_c_t c;
    #2;
    if (qc.size() > 0) begin
      c = qc.pop_front();
      vectors++;
      if (pkt_waiting_out !== c.pwo || tx_strobe_out !== c.tso) begin
        miscompares++;
        $display("FAIL gated t=%0t got pwo=%b tso=%b want pwo=%b tso=%b",
                 $time, pkt_waiting_out, tx_strobe_out, c.pwo, c.tso);
      end
    end
  end

  always @(posedge tx_clock) begin
    exp_r_t e;
    #1;
    if (qr.size() > 0) begin
      e = qr.pop_front();
      vectors++;
      if (grant !== e.grant || burst_lock !== e.lock ||
          timeout_err !== e.terr || tx_i !== e.ti || tx_q !== e.tq ||
          tx_empty !== e.te || debug !== e.dbg) begin
        miscompares++;
        $display("FAIL regs t=%0t got g=%b bl=%b te=%b i=%h q=%h e=%b d=%h want g=%b bl=%b te=%b i=%h q=%h e=%b d=%h",
                 $time, grant, burst_lock, timeout_err, tx_i, tx_q,
                 tx_empty, debug, e.grant, e.lock, e.terr, e.ti, e.tq,
                 e.te, e.dbg);
      end
    end
  end

  task automatic do_reset();
    g_rst = 1; g_pw = 0; g_sob = 0; g_eob = 0;
    repeat (2) cycle();
    g_rst = 0;
  endtask

  initial begin
    do_reset();

    // Two steady requesters, each grant ended by a skip.
    g_pw = 4'b0101;
    repeat (4) begin
      repeat (3) begin g_ts = 1'($urandom); cycle(); end
      g_sk = own_mask();
      cycle();
    end

    // Burst on ch2 with ch1 waiting, then EOB packet closes it.
    do_reset();
    g_pw = 4'b0100; g_sob = 4'b0100; g_eob = 0;
    repeat (2) cycle();
    g_pw = 4'b0010; g_sob = 0;
    g_sk = 4'b0100;
    cycle();
    repeat (10) cycle();
    g_pw = 4'b0110; g_eob = 4'b0100;
    repeat (3) cycle();
    g_eob = 0; g_pw = 4'b0010;
    g_sk = 4'b0100;
    cycle();
    repeat (4) cycle();

    // Open burst on ch3 then starve it until the hold expires.
    do_reset();
    g_pw = 4'b1000; g_sob = 4'b1000;
    repeat (2) cycle();
    g_pw = 0; g_sob = 0; g_sk = 4'b1000;
    cycle();
    repeat (HT + 4) begin g_ts = 1'($urandom); cycle(); end

    // Reset while ch2 is active.
    g_pw = 4'b0100;
    repeat (3) cycle();
    g_rst = 1;
    cycle();
    g_rst = 0; g_pw = 0;
    repeat (2) cycle();

    // All four requesting.
    g_pw = 4'b1111;
    repeat (8) begin
      repeat (2) cycle();
      g_sk = own_mask();
      cycle();
    end

    // Dense random traffic.
    repeat (800) begin
      g_rst = ($urandom_range(0, 199) == 0);
      g_pw  = 4'($urandom);
      g_sk  = 4'($urandom) & 4'($urandom);
      g_sob = 4'($urandom);
      g_eob = 4'($urandom) & 4'($urandom);
      g_ts  = 1'($urandom);
      cycle();
    end

    // Sparse requests so bursts stall and time out.
    g_rst = 0;
    repeat (800) begin
      for (int k = 0; k < N; k++)
        g_pw[k] = ($urandom_range(0, 29) == 0);
      g_sk  = ($urandom_range(0, 3) == 0) ? own_mask() : 4'd0;
      g_sob = 4'($urandom);
      g_eob = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      g_ts  = 1'($urandom);
      cycle();
    end

    repeat (3) @(negedge tx_clock);
    vectors++;
    if (qr.size() != 0 || qc.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d/%0d pending want 0/0", qr.size(), qc.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
